dcache_nway: RTL

DCACHE_NWAY -- requirements
Module: dcache_nway

---
 rtl/dcache_nway.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with true-LRU replacement and halt-driven flush.
// Hits answer combinationally in IDLE; misses stall (dhit=0) while the victim is written back and the block refilled.
module dcache_nway #(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        halt,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic        flushed,
  output logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int BW = $clog2(WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - BW - IW;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [BW-1:0] LAST_WORD = BW'(WORDS - 1);
  localparam logic [WW-1:0] LAST_WAY  = WW'(WAYS - 1);
  localparam logic [IW-1:0] LAST_SET  = IW'(SETS - 1);

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} state_t;

  logic [TW-1:0]   r_tag   [SETS][WAYS];
  logic [31:0]     r_data  [SETS][WAYS][WORDS];
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-1:0] r_dirty [SETS];
  logic [WW-1:0]   r_age   [SETS][WAYS];

  state_t        r_state, w_next;
  logic [BW-1:0] r_cnt;
  logic [WW-1:0] r_way;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_req_tag;
  logic [IW-1:0] r_fset;
  logic [WW-1:0] r_fway;
  logic [31:0]   r_hit_cnt, r_miss_cnt;

  logic [BW-1:0] w_boff;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_req, w_hit, w_miss, w_wr_hit;
  logic [WW-1:0] w_hway, w_vway, w_vage;
  logic          w_wb_last, w_fetch_beat, w_fetch_last;
  logic          w_fl_dirty, w_fl_last_word, w_fl_adv, w_fl_end;
  logic          w_lru_en;
  logic [IW-1:0] w_lru_set;
  logic [WW-1:0] w_lru_way, w_lru_old;

  assign w_boff = dmemaddr[2 +: BW];
  assign w_idx  = dmemaddr[2 + BW +: IW];
  assign w_tag  = dmemaddr[31 -: TW];
  assign w_req  = dmemREN | dmemWEN;

  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit  = 1'b1;
        w_hway = WW'(w);
      end
    end
  end

  // Oldest way wins (lowest index on ties), but any invalid way overrides it.
  always_comb begin
    w_vway = '0;
    w_vage = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[w_idx][w] > w_vage) begin
        w_vage = r_age[w_idx][w];
        w_vway = WW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_vway = WW'(w);
    end
  end

  assign dhit           = (r_state == IDLE) && w_req && w_hit;
  assign w_miss         = (r_state == IDLE) && !halt && w_req && !w_hit;
  assign w_wr_hit       = dhit && dmemWEN;
  assign dmemload       = (dhit && dmemREN) ? r_data[w_idx][w_hway][w_boff] : 32'h0;
  assign w_wb_last      = (r_state == WB) && !dwait && (r_cnt == LAST_WORD);
  assign w_fetch_beat   = (r_state == FETCH) && !dwait;
  assign w_fetch_last   = w_fetch_beat && (r_cnt == LAST_WORD);
  assign w_fl_dirty     = r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway];
  assign w_fl_last_word = (r_state == FLUSH) && w_fl_dirty && !dwait && (r_cnt == LAST_WORD);
  assign w_fl_adv       = (r_state == FLUSH) && (!w_fl_dirty || w_fl_last_word);
  assign w_fl_end       = w_fl_adv && (r_fset == LAST_SET) && (r_fway == LAST_WAY);
  assign flushed        = (r_state == DONE);
  assign hit_count      = r_hit_cnt;
  assign miss_count     = r_miss_cnt;

  // A fill into an empty way treats it as the oldest, so empty sets build a proper order.
  assign w_lru_en  = dhit || w_fetch_last;
  assign w_lru_set = dhit ? w_idx : r_idx;
  assign w_lru_way = dhit ? w_hway : r_way;
  assign w_lru_old = dhit ? r_age[w_idx][w_hway] :
                     (r_valid[r_idx][r_way] ? r_age[r_idx][r_way] : LAST_WAY);

  always_comb begin
    w_next = r_state;
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = dmemaddr;
    dstore = 32'h0;
    case (r_state)
      IDLE: begin
        if (halt) w_next = FLUSH;
        else if (w_miss)
          w_next = (r_valid[w_idx][w_vway] && r_dirty[w_idx][w_vway]) ? WB : FETCH;
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {r_tag[r_idx][r_way], r_idx, r_cnt, 2'b00};
        dstore = r_data[r_idx][r_way][r_cnt];
        if (w_wb_last) w_next = FETCH;
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = {r_req_tag, r_idx, r_cnt, 2'b00};
        if (w_fetch_last) w_next = IDLE;
      end
      FLUSH: begin
        if (w_fl_dirty) begin
          dWEN   = 1'b1;
          daddr  = {r_tag[r_fset][r_fway], r_fset, r_cnt, 2'b00};
          dstore = r_data[r_fset][r_fway][r_cnt];
        end
        if (w_fl_end) w_next = DONE;
      end
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_way      <= '0;
      r_idx      <= '0;
      r_req_tag  <= '0;
      r_fset     <= '0;
      r_fway     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (dhit) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_fetch_last) r_miss_cnt <= r_miss_cnt + 32'd1;
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_fset <= '0;
          r_fway <= '0;
          if (w_miss) begin
            r_way     <= w_vway;
            r_idx     <= w_idx;
            r_req_tag <= w_tag;
          end
        end
        WB, FETCH: begin
          if (!dwait) r_cnt <= r_cnt + 1'b1;
        end
        FLUSH: begin
          if (w_fl_dirty && !dwait) r_cnt <= r_cnt + 1'b1;
          if (w_fl_adv) begin
            if (r_fway == LAST_WAY) begin
              r_fway <= '0;
              r_fset <= r_fset + 1'b1;
            end else begin
              r_fway <= r_fway + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= '0;
      end
    end else begin
      if (w_wr_hit) r_dirty[w_idx][w_hway] <= 1'b1;
      if (w_wb_last) r_dirty[r_idx][r_way] <= 1'b0;
      if (w_fetch_last) begin
        r_valid[r_idx][r_way] <= 1'b1;
        r_dirty[r_idx][r_way] <= 1'b0;
      end
      if (w_fl_last_word) r_dirty[r_fset][r_fway] <= 1'b0;
      if (w_lru_en) begin
        for (int j = 0; j < WAYS; j++) begin
          if (WW'(j) == w_lru_way) r_age[w_lru_set][j] <= '0;
          else if (r_age[w_lru_set][j] < w_lru_old)
            r_age[w_lru_set][j] <= r_age[w_lru_set][j] + 1'b1;
        end
      end
    end
  end

  // Tags and data need no reset: valid bits gate every use of them.
  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_idx][w_hway][w_boff] <= dmemstore;
    if (w_fetch_beat) r_data[r_idx][r_way][r_cnt] <= dload;
    if (w_fetch_last) r_tag[r_idx][r_way] <= r_req_tag;
  end

endmodule
